// File: rtl/dmem_arbiter_if.sv
// Request/response and byte-memory bus shared by the two data-memory
// requesters, the arbiter and the byte-wide memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 5
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [31:0]       addr0;
    logic [31:0]       addr1;
    logic [31:0]       wdata0;
    logic [31:0]       wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [31:0]       rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata;

    modport slave (
        input  req0, req1, we0, we1,
        input  addr0, addr1, wdata0, wdata1,
        input  mem_rdata,
        output gnt0, gnt1, done0, done1,
        output rdata, busy,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req0, req1, we0, we1,
        output addr0, addr1, wdata0, wdata1,
        output mem_rdata,
        input  gnt0, gnt1, done0, done1,
        input  rdata, busy,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the byte-wide data memory; splits each word
// access into four big-endian byte beats and reassembles read words.
module dmem_arbiter #(
    parameter int ADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_arbiter_if.slave   bus
);
    localparam int WW = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WAIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [WW-1:0]     word_q, word_d;
    logic [23:0]       wdata_q, wdata_d;
    logic [23:0]       asm_q, asm_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              sel0, sel1;
    logic [31:0]       wsel;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        last_d      = last_q;
        owner_d     = owner_q;
        we_d        = we_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        rdata_d     = rdata_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        // On a tie, the port that did not win last time goes first
        sel1 = bus.req1 & (~bus.req0 | ~last_q);
        sel0 = bus.req0 & ~sel1;
        wsel = sel1 ? bus.wdata1 : bus.wdata0;

        unique case (state_q)
            IDLE: begin
                if (sel0 | sel1) begin
                    state_d     = XFER;
                    owner_d     = sel1;
                    last_d      = sel1;
                    we_d        = sel1 ? bus.we1 : bus.we0;
                    word_d      = sel1 ? bus.addr1[ADDR_W-1:2]
                                       : bus.addr0[ADDR_W-1:2];
                    wdata_d     = wsel[23:0];
                    beat_d      = 2'd0;
                    gnt0_d      = sel0;
                    gnt1_d      = sel1;
                    mem_addr_d  = {word_d, 2'd0};
                    mem_we_d    = we_d;
                    mem_wdata_d = we_d ? wsel[31:24] : 8'h00;
                end
            end
            XFER: begin
                // Registered memory: byte for beat b-1 arrives during beat b
                if (!we_q) begin
                    unique case (beat_q)
                        2'd1:    asm_d[23:16] = bus.mem_rdata;
                        2'd2:    asm_d[15:8]  = bus.mem_rdata;
                        2'd3:    asm_d[7:0]   = bus.mem_rdata;
                        default: asm_d        = asm_q;
                    endcase
                end
                if (beat_q == 2'd3) begin
                    state_d     = WAIT;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = 8'h00;
                end else begin
                    beat_d     = beat_q + 2'd1;
                    mem_addr_d = {word_q, beat_d};
                    if (we_q) begin
                        unique case (beat_d)
                            2'd1:    mem_wdata_d = wdata_q[23:16];
                            2'd2:    mem_wdata_d = wdata_q[15:8];
                            default: mem_wdata_d = wdata_q[7:0];
                        endcase
                    end else begin
                        mem_wdata_d = 8'h00;
                    end
                end
            end
            WAIT: begin
                state_d = RESP;
                beat_d  = 2'd0;
                done0_d = ~owner_q;
                done1_d = owner_q;
                if (!we_q) begin
                    rdata_d = {asm_q, bus.mem_rdata};
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            rdata_q     <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            rdata_q     <= rdata_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte memory plus a word-level reference model,
// directed scenarios followed by random accesses.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(5)) bus();

    dmem_arbiter #(.ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [32];
    logic [7:0] mrd;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
            mrd <= 8'h00;
        end else begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            mrd <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = mrd;

    logic [7:0]  ref_mem [32];
    logic [31:0] ref_rdata;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt0"}, 32'(bus.gnt0), 32'd0);
        chk({tag, "_gnt1"}, 32'(bus.gnt1), 32'd0);
        chk({tag, "_done0"}, 32'(bus.done0), 32'd0);
        chk({tag, "_done1"}, 32'(bus.done1), 32'd0);
        chk({tag, "_rdata"}, bus.rdata, 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_maddr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mwdata"}, 32'(bus.mem_wdata), 32'd0);
        chk({tag, "_mwe"}, 32'(bus.mem_we), 32'd0);
    endtask

    // One complete access from an idle arbiter, checked cycle by cycle
    task automatic access(input int p, input bit w, input logic [31:0] a,
                          input logic [31:0] d);
        int n;
        logic [2:0] wd;
        logic gp, dp, dq;
        wd = a[4:2];
        if (!w) begin
            ref_rdata = {ref_mem[{wd, 2'd0}], ref_mem[{wd, 2'd1}],
                         ref_mem[{wd, 2'd2}], ref_mem[{wd, 2'd3}]};
        end
        if (p == 0) begin
            bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
        n = 0;
        do begin
            tick();
            n++;
            gp = (p == 0) ? bus.gnt0 : bus.gnt1;
        end while (!gp && n < 20);
        chk("gnt_latency", 32'(n), 32'd1);
        if (p == 0) begin
            bus.req0 = 1'b0; bus.we0 = 1'($urandom);
            bus.addr0 = $urandom; bus.wdata0 = $urandom;
        end else begin
            bus.req1 = 1'b0; bus.we1 = 1'($urandom);
            bus.addr1 = $urandom; bus.wdata1 = $urandom;
        end
        for (int b = 0; b < 4; b++) begin
            if (b > 0) tick();
            gp = (p == 0) ? bus.gnt0 : bus.gnt1;
            chk("gnt_pulse", 32'(gp), 32'(b == 0));
            chk("beat_addr", 32'(bus.mem_addr), 32'({wd, b[1:0]}));
            chk("beat_we", 32'(bus.mem_we), 32'(w));
            chk("beat_busy", 32'(bus.busy), 32'd1);
            if (w) begin
                chk("beat_wdata", 32'(bus.mem_wdata), 32'(d[31-8*b -: 8]));
                ref_mem[{wd, b[1:0]}] = d[31-8*b -: 8];
            end
        end
        tick();
        dp = (p == 0) ? bus.done0 : bus.done1;
        chk("wait_we", 32'(bus.mem_we), 32'd0);
        chk("wait_done", 32'(dp), 32'd0);
        chk("wait_busy", 32'(bus.busy), 32'd1);
        tick();
        dp = (p == 0) ? bus.done0 : bus.done1;
        dq = (p == 0) ? bus.done1 : bus.done0;
        chk("resp_done", 32'(dp), 32'd1);
        chk("resp_other_done", 32'(dq), 32'd0);
        chk("resp_rdata", bus.rdata, ref_rdata);
        chk("resp_busy", 32'(bus.busy), 32'd1);
        tick();
        dp = (p == 0) ? bus.done0 : bus.done1;
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(dp), 32'd0);
    endtask

    initial begin
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        ref_rdata = 32'd0;
        repeat (3) tick();
        clr = 1'b0;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        access(0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        access(1, 1'b0, 32'h0000_0008, 32'h0);
        access(1, 1'b0, 32'h0000_001F, 32'h0);
        access(1, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5);

        // Single requester holding req: grant every 7 cycles
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h4;
        for (int i = 1; i <= 21; i++) begin
            tick();
            chk("solo_gnt0", 32'(bus.gnt0), 32'(i % 7 == 1));
            chk("solo_done0", 32'(bus.done0), 32'(i % 7 == 6));
            chk("solo_busy", 32'(bus.busy), 32'(i % 7 != 0));
            chk("solo_gnt1", 32'(bus.gnt1), 32'd0);
            if (i == 21) bus.req0 = 1'b0;
        end
        ref_rdata = {ref_mem[4], ref_mem[5], ref_mem[6], ref_mem[7]};
        chk("solo_rdata", bus.rdata, ref_rdata);

        // Reset during beat 2 of a write
        bus.req0 = 1'b1; bus.we0 = 1'b1;
        bus.addr0 = 32'h10; bus.wdata0 = 32'h1122_3344;
        tick();
        chk("abort_gnt", 32'(bus.gnt0), 32'd1);
        bus.req0 = 1'b0;
        tick();
        tick();
        chk("abort_beat2_addr", 32'(bus.mem_addr), 32'h12);
        chk("abort_beat2_we", 32'(bus.mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        ref_mem[16] = 8'h11;
        ref_mem[17] = 8'h22;
        ref_rdata = 32'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_done", 32'(bus.done0), 32'd0);
            chk("abort_idle_busy", 32'(bus.busy), 32'd0);
        end

        // Simultaneous requests alternate, port 0 first after reset
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h4;
        for (int i = 1; i <= 28; i++) begin
            tick();
            chk("tie_gnt0", 32'(bus.gnt0), 32'(i % 14 == 1));
            chk("tie_gnt1", 32'(bus.gnt1), 32'(i % 14 == 8));
            chk("tie_done0", 32'(bus.done0), 32'(i % 14 == 6));
            chk("tie_done1", 32'(bus.done1), 32'(i % 14 == 13));
            if (i == 28) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end

        access(0, 1'b0, 32'h0000_0010, 32'h0);
        chk("abort_bytes", bus.rdata, 32'h1122_A5A5);

        repeat (40) begin
            access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
